// File: rtl/gb_scatter_gather_ctrl.sv
`default_nettype none
//==============================================================================
// Module      : gb_scatter_gather_ctrl
// Description : Global-buffer scatter/gather controller for the PE array.
//               Scatters filter (broadcast or per-lane) and IFMap (per-lane)
//               words into lane FIFOs under backpressure, pulses the PE start,
//               then gathers the last lane's psum stream back into the global
//               buffer. Only addresses and enables are produced here.
// Revision    : 1.0 - initial release
//==============================================================================
module gb_scatter_gather_ctrl #(
   parameter int N          = 4,
   parameter int N_WIDTH    = 2,
   parameter int ADDR_WIDTH = 10,
   parameter int LEN_WIDTH  = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_start,
   input  logic                  i_filter_unicast,
   input  logic [ADDR_WIDTH-1:0] i_filter_base,
   input  logic [LEN_WIDTH-1:0]  i_filter_len,
   input  logic [ADDR_WIDTH-1:0] i_ifmap_base,
   input  logic [LEN_WIDTH-1:0]  i_ifmap_len,
   input  logic [ADDR_WIDTH-1:0] i_psum_base,
   input  logic [LEN_WIDTH-1:0]  i_psum_len,
   input  logic [N-1:0]          i_lane_ready_filter,
   input  logic [N-1:0]          i_lane_ready_ifmap,
   input  logic                  i_psum_valid,
   output logic [ADDR_WIDTH-1:0] o_gb_raddr,
   output logic [ADDR_WIDTH-1:0] o_gb_waddr,
   output logic                  o_gb_wen,
   output logic [N-1:0]          o_wen_filter,
   output logic [N-1:0]          o_wen_ifmap,
   output logic                  o_psum_ren,
   output logic                  o_start_pe,
   output logic                  o_busy,
   output logic                  o_done
);

   // Products lane*len are formed wide enough never to overflow before the
   // final modulo-2^ADDR_WIDTH truncation of the address sum.
   localparam int                 c_PW        = ADDR_WIDTH + LEN_WIDTH;
   localparam logic [N_WIDTH-1:0] c_LAST_LANE = N_WIDTH'(N - 1);
   localparam logic [N-1:0]       c_ALL_LANES = {N{1'b1}};

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FIL_RD = 3'd1,
      S_FIL_WR = 3'd2,
      S_IFM_RD = 3'd3,
      S_IFM_WR = 3'd4,
      S_PE_GO  = 3'd5,
      S_GATHER = 3'd6,
      S_DONE   = 3'd7
   } state_t;

   state_t                r_state;
   logic [N_WIDTH-1:0]    r_lane;
   logic [LEN_WIDTH-1:0]  r_word;
   logic [LEN_WIDTH-1:0]  r_pcount;

   // Job parameters captured at start-accept
   logic                  r_fil_uni;
   logic [ADDR_WIDTH-1:0] r_fil_base;
   logic [LEN_WIDTH-1:0]  r_fil_len;
   logic [ADDR_WIDTH-1:0] r_ifm_base;
   logic [LEN_WIDTH-1:0]  r_ifm_len;
   logic [ADDR_WIDTH-1:0] r_psum_base;
   logic [LEN_WIDTH-1:0]  r_psum_len;

   // Registered FSM outputs
   logic [N-1:0]          r_wen_filter;
   logic [N-1:0]          r_wen_ifmap;
   logic                  r_start_pe;
   logic                  r_busy;
   logic                  r_done;

   logic [c_PW-1:0]       w_fil_prod;
   logic [c_PW-1:0]       w_ifm_prod;
   logic [c_PW-1:0]       w_fil_sum;
   logic [c_PW-1:0]       w_ifm_sum;
   logic [ADDR_WIDTH-1:0] w_psum_addr;
   logic [N-1:0]          w_lane_hot;
   logic                  w_fil_ready;
   logic                  w_ifm_ready;
   logic                  w_fil_word_last;
   logic                  w_ifm_word_last;
   logic                  w_pcount_last;
   logic                  w_in_fil;
   logic                  w_in_ifm;
   logic                  w_in_gather;
   logic                  w_unused_hi;

   // Address arithmetic, target-ready selection and end-of-run detection
   always_comb begin
      w_fil_prod      = r_fil_uni ? (c_PW'(r_lane) * c_PW'(r_fil_len)) : '0;
      w_ifm_prod      = c_PW'(r_lane) * c_PW'(r_ifm_len);
      w_fil_sum       = c_PW'(r_fil_base) + w_fil_prod + c_PW'(r_word);
      w_ifm_sum       = c_PW'(r_ifm_base) + w_ifm_prod + c_PW'(r_word);
      w_psum_addr     = r_psum_base + ADDR_WIDTH'(r_pcount);
      w_lane_hot      = N'(1) << r_lane;
      w_fil_ready     = r_fil_uni ? i_lane_ready_filter[r_lane] : (&i_lane_ready_filter);
      w_ifm_ready     = i_lane_ready_ifmap[r_lane];
      w_fil_word_last = ((r_word + LEN_WIDTH'(1)) == r_fil_len);
      w_ifm_word_last = ((r_word + LEN_WIDTH'(1)) == r_ifm_len);
      w_pcount_last   = ((r_pcount + LEN_WIDTH'(1)) == r_psum_len);
      w_in_fil        = (r_state == S_FIL_RD) || (r_state == S_FIL_WR);
      w_in_ifm        = (r_state == S_IFM_RD) || (r_state == S_IFM_WR);
      w_in_gather     = (r_state == S_GATHER);
      // Bits above ADDR_WIDTH are discarded by design (address wrap-around)
      w_unused_hi     = ^{w_fil_sum[c_PW-1:ADDR_WIDTH], w_ifm_sum[c_PW-1:ADDR_WIDTH]};
   end

   // Read address is held through the *_WR cycle so the 1-cycle GB read lines
   // up with the FIFO write; gather pops and writes back in the same cycle.
   always_comb begin
      o_gb_raddr = '0;
      if (w_in_fil) begin
         o_gb_raddr = w_fil_sum[ADDR_WIDTH-1:0];
      end else if (w_in_ifm) begin
         o_gb_raddr = w_ifm_sum[ADDR_WIDTH-1:0];
      end
      o_gb_waddr   = w_in_gather ? w_psum_addr : '0;
      o_gb_wen     = w_in_gather & i_psum_valid;
      o_psum_ren   = w_in_gather & i_psum_valid;
      o_wen_filter = r_wen_filter;
      o_wen_ifmap  = r_wen_ifmap;
      o_start_pe   = r_start_pe;
      o_busy       = r_busy;
      o_done       = r_done;
   end

   // Control FSM: sequencing, counters, parameter capture and pulse outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= S_IDLE;
         r_lane       <= '0;
         r_word       <= '0;
         r_pcount     <= '0;
         r_fil_uni    <= 1'b0;
         r_fil_base   <= '0;
         r_fil_len    <= '0;
         r_ifm_base   <= '0;
         r_ifm_len    <= '0;
         r_psum_base  <= '0;
         r_psum_len   <= '0;
         r_wen_filter <= '0;
         r_wen_ifmap  <= '0;
         r_start_pe   <= 1'b0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
      end else begin
         // Pulse outputs default low; each lasts exactly one state cycle
         r_wen_filter <= '0;
         r_wen_ifmap  <= '0;
         r_start_pe   <= 1'b0;
         r_done       <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (i_start) begin
                  r_fil_uni   <= i_filter_unicast;
                  r_fil_base  <= i_filter_base;
                  r_fil_len   <= i_filter_len;
                  r_ifm_base  <= i_ifmap_base;
                  r_ifm_len   <= i_ifmap_len;
                  r_psum_base <= i_psum_base;
                  r_psum_len  <= i_psum_len;
                  r_lane      <= '0;
                  r_word      <= '0;
                  r_pcount    <= '0;
                  r_busy      <= 1'b1;
                  if (i_filter_len != '0) begin
                     r_state <= S_FIL_RD;
                  end else if (i_ifmap_len != '0) begin
                     r_state <= S_IFM_RD;
                  end else begin
                     r_state    <= S_PE_GO;
                     r_start_pe <= 1'b1;
                  end
               end
            end
            S_FIL_RD: begin
               if (w_fil_ready) begin
                  r_state      <= S_FIL_WR;
                  r_wen_filter <= r_fil_uni ? w_lane_hot : c_ALL_LANES;
               end
            end
            S_FIL_WR: begin
               if (w_fil_word_last) begin
                  r_word <= '0;
                  if (r_fil_uni && (r_lane < c_LAST_LANE)) begin
                     r_lane  <= r_lane + N_WIDTH'(1);
                     r_state <= S_FIL_RD;
                  end else begin
                     r_lane <= '0;
                     if (r_ifm_len != '0) begin
                        r_state <= S_IFM_RD;
                     end else begin
                        r_state    <= S_PE_GO;
                        r_start_pe <= 1'b1;
                     end
                  end
               end else begin
                  r_word  <= r_word + LEN_WIDTH'(1);
                  r_state <= S_FIL_RD;
               end
            end
            S_IFM_RD: begin
               if (w_ifm_ready) begin
                  r_state     <= S_IFM_WR;
                  r_wen_ifmap <= w_lane_hot;
               end
            end
            S_IFM_WR: begin
               if (w_ifm_word_last) begin
                  r_word <= '0;
                  if (r_lane < c_LAST_LANE) begin
                     r_lane  <= r_lane + N_WIDTH'(1);
                     r_state <= S_IFM_RD;
                  end else begin
                     r_lane     <= '0;
                     r_state    <= S_PE_GO;
                     r_start_pe <= 1'b1;
                  end
               end else begin
                  r_word  <= r_word + LEN_WIDTH'(1);
                  r_state <= S_IFM_RD;
               end
            end
            S_PE_GO: begin
               if (r_psum_len == '0) begin
                  r_state <= S_DONE;
                  r_done  <= 1'b1;
               end else begin
                  r_state <= S_GATHER;
               end
            end
            S_GATHER: begin
               if (i_psum_valid) begin
                  r_pcount <= r_pcount + LEN_WIDTH'(1);
                  if (w_pcount_last) begin
                     r_state <= S_DONE;
                     r_done  <= 1'b1;
                  end
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_gb_scatter_gather_ctrl.sv
`default_nettype none
//==============================================================================
// Module      : tb_gb_scatter_gather_ctrl
// Description : Scoreboard bench for gb_scatter_gather_ctrl. Expected write,
//               start and done events are queued when a job is launched and
//               popped as the DUT produces them.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_gb_scatter_gather_ctrl;
   localparam int N          = 4;
   localparam int N_WIDTH    = 2;
   localparam int ADDR_WIDTH = 10;
   localparam int LEN_WIDTH  = 8;

   logic                  clk = 1'b0;
   logic                  rst_n = 1'b0;
   logic                  i_start = 1'b0;
   logic                  i_filter_unicast = 1'b0;
   logic [ADDR_WIDTH-1:0] i_filter_base = '0;
   logic [LEN_WIDTH-1:0]  i_filter_len = '0;
   logic [ADDR_WIDTH-1:0] i_ifmap_base = '0;
   logic [LEN_WIDTH-1:0]  i_ifmap_len = '0;
   logic [ADDR_WIDTH-1:0] i_psum_base = '0;
   logic [LEN_WIDTH-1:0]  i_psum_len = '0;
   logic [N-1:0]          i_lane_ready_filter = '1;
   logic [N-1:0]          i_lane_ready_ifmap = '1;
   logic                  i_psum_valid = 1'b0;
   logic [ADDR_WIDTH-1:0] o_gb_raddr;
   logic [ADDR_WIDTH-1:0] o_gb_waddr;
   logic                  o_gb_wen;
   logic [N-1:0]          o_wen_filter;
   logic [N-1:0]          o_wen_ifmap;
   logic                  o_psum_ren;
   logic                  o_start_pe;
   logic                  o_busy;
   logic                  o_done;

   gb_scatter_gather_ctrl #(
      .N(N), .N_WIDTH(N_WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .LEN_WIDTH(LEN_WIDTH)
   ) u_dut (
      .clk                 (clk),
      .rst_n               (rst_n),
      .i_start             (i_start),
      .i_filter_unicast    (i_filter_unicast),
      .i_filter_base       (i_filter_base),
      .i_filter_len        (i_filter_len),
      .i_ifmap_base        (i_ifmap_base),
      .i_ifmap_len         (i_ifmap_len),
      .i_psum_base         (i_psum_base),
      .i_psum_len          (i_psum_len),
      .i_lane_ready_filter (i_lane_ready_filter),
      .i_lane_ready_ifmap  (i_lane_ready_ifmap),
      .i_psum_valid        (i_psum_valid),
      .o_gb_raddr          (o_gb_raddr),
      .o_gb_waddr          (o_gb_waddr),
      .o_gb_wen            (o_gb_wen),
      .o_wen_filter        (o_wen_filter),
      .o_wen_ifmap         (o_wen_ifmap),
      .o_psum_ren          (o_psum_ren),
      .o_start_pe          (o_start_pe),
      .o_busy              (o_busy),
      .o_done              (o_done)
   );

   always #5 clk = ~clk;

   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          busy_cnt = 0;
   int          ren_cnt = 0;
   logic        mon_en = 1'b0;
   logic [31:0] exp_q[$];
   int          ev_cyc[$];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Event word: kind[27:24] (0 filter wr, 1 ifmap wr, 2 psum wr, 3 start_pe, 4 done),
   // address[17:8], lane mask[7:0]
   function automatic logic [31:0] ev(input int kind, input int addr, input int mask);
      return (32'(kind) << 24) | ((32'(addr) & 32'h3FF) << 8) | (32'(mask) & 32'hFF);
   endfunction

   task automatic sb_take(input string tag, input logic [31:0] obs);
      logic [31:0] e;
      ev_cyc.push_back(cyc);
      if (exp_q.size() == 0) e = 32'hFFFF_FFFF;
      else e = exp_q.pop_front();
      check_val(tag, obs, e);
   endtask

   // Monitor: every DUT-produced event is compared with the scoreboard head
   always @(negedge clk) begin
      if (mon_en) begin
         if (o_busy) busy_cnt++;
         if (o_psum_ren) ren_cnt++;
         if (|o_wen_filter) sb_take("filter_wr", ev(0, int'(o_gb_raddr), int'(o_wen_filter)));
         if (|o_wen_ifmap)  sb_take("ifmap_wr",  ev(1, int'(o_gb_raddr), int'(o_wen_ifmap)));
         if (o_gb_wen)      sb_take("psum_wr",   ev(2, int'(o_gb_waddr), 0));
         if (o_start_pe)    sb_take("start_pe",  ev(3, 0, 0));
         if (o_done)        sb_take("done",      ev(4, 0, 0));
      end
   end

   // Reference model of the event stream of one job
   task automatic push_expected(input int fu, input int fb, input int fl, input int ib,
                                input int il, input int pb, input int pl);
      int nl;
      nl = (fu != 0) ? N : 1;
      for (int l = 0; l < nl; l++)
         for (int w = 0; w < fl; w++)
            exp_q.push_back(ev(0, fb + l * ((fu != 0) ? fl : 0) + w, (fu != 0) ? (1 << l) : 'hF));
      for (int l = 0; l < N; l++)
         for (int w = 0; w < il; w++)
            exp_q.push_back(ev(1, ib + l * il + w, 1 << l));
      exp_q.push_back(ev(3, 0, 0));
      for (int p = 0; p < pl; p++)
         exp_q.push_back(ev(2, pb + p, 0));
      exp_q.push_back(ev(4, 0, 0));
   endtask

   task automatic run_job(input int fu, input int fb, input int fl, input int ib,
                          input int il, input int pb, input int pl);
      push_expected(fu, fb, fl, ib, il, pb, pl);
      @(posedge clk); #1;
      i_filter_unicast = fu[0];
      i_filter_base    = ADDR_WIDTH'(fb);
      i_filter_len     = LEN_WIDTH'(fl);
      i_ifmap_base     = ADDR_WIDTH'(ib);
      i_ifmap_len      = LEN_WIDTH'(il);
      i_psum_base      = ADDR_WIDTH'(pb);
      i_psum_len       = LEN_WIDTH'(pl);
      i_start          = 1'b1;
      @(posedge clk); #1;
      i_start          = 1'b0;
      // Parameters are latched; scramble the inputs to prove it
      i_filter_unicast = 1'($urandom);
      i_filter_base    = ADDR_WIDTH'($urandom);
      i_filter_len     = LEN_WIDTH'($urandom);
      i_ifmap_base     = ADDR_WIDTH'($urandom);
      i_ifmap_len      = LEN_WIDTH'($urandom);
      i_psum_base      = ADDR_WIDTH'($urandom);
      i_psum_len       = LEN_WIDTH'($urandom);
   endtask

   task automatic wait_idle(input string tag, input int budget);
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (!o_busy) break;
      end
      check_val(tag, 32'(o_busy), 32'd0);
   endtask

   task automatic clear_stats();
      busy_cnt = 0;
      ren_cnt  = 0;
      ev_cyc.delete();
   endtask

   task automatic check_outputs_zero(input string tag);
      check_val({tag, "_addr"}, {12'd0, o_gb_raddr, o_gb_waddr}, 32'd0);
      check_val({tag, "_ctl"}, {19'd0, o_gb_wen, o_wen_filter, o_wen_ifmap, o_psum_ren,
                                o_start_pe, o_busy, o_done}, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      // ---------------- reset state ----------------
      i_psum_valid = 1'b1;
      #1;
      check_outputs_zero("reset_init");
      i_psum_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      mon_en = 1'b1;

      // ---------------- job 1: broadcast filter ----------------
      clear_stats();
      run_job(0, 'h10, 3, 0, 0, 0, 0);
      wait_idle("job1_idle", 100);
      check_val("job1_sb_empty", 32'(exp_q.size()), 32'd0);
      check_val("job1_busy_cycles", 32'(busy_cnt), 32'd8);
      check_val("job1_event_count", 32'(ev_cyc.size()), 32'd5);
      if (ev_cyc.size() == 5) begin
         check_val("job1_wen_gap0", 32'(ev_cyc[1] - ev_cyc[0]), 32'd2);
         check_val("job1_wen_gap1", 32'(ev_cyc[2] - ev_cyc[1]), 32'd2);
         check_val("job1_pe_gap", 32'(ev_cyc[3] - ev_cyc[2]), 32'd1);
         check_val("job1_done_gap", 32'(ev_cyc[4] - ev_cyc[3]), 32'd1);
      end

      // ---------------- job 2: unicast + backpressure + gather ----------------
      clear_stats();
      i_lane_ready_ifmap = 4'b1101;
      fork
         run_job(1, 'h20, 2, 'h40, 2, 'h3FE, 4);
         begin : g_backpressure
            for (int i = 0; i < 300; i++) begin
               @(negedge clk);
               if (o_gb_raddr == ADDR_WIDTH'('h42)) break;
            end
            for (int k = 0; k < 5; k++) begin
               check_val("bp_raddr_held", 32'(o_gb_raddr), 32'h42);
               check_val("bp_no_wen_ifmap", 32'(o_wen_ifmap), 32'd0);
               if (k < 4) @(negedge clk);
            end
            @(posedge clk); #1;
            i_lane_ready_ifmap = 4'b1111;
         end
         begin : g_gather
            logic [5:0] pat;
            pat = 6'b111101;  // index 0 first: 1,0,1,1,1, then 1 during DONE
            for (int i = 0; i < 300; i++) begin
               @(negedge clk);
               if (o_start_pe) break;
            end
            check_val("gather_saw_start_pe", 32'(o_start_pe), 32'd1);
            for (int i = 0; i < 6; i++) begin
               @(posedge clk); #1;
               i_psum_valid = pat[i];
               i_start      = (i == 1) || (i == 5);
            end
            @(posedge clk); #1;
            i_psum_valid = 1'b0;
            i_start      = 1'b0;
         end
      join
      wait_idle("job2_idle", 300);
      check_val("job2_sb_empty", 32'(exp_q.size()), 32'd0);
      check_val("job2_psum_ren_count", 32'(ren_cnt), 32'd4);
      repeat (3) @(negedge clk);
      check_val("start_in_done_ignored", 32'(o_busy), 32'd0);

      // ---------------- job 3: accepted from IDLE after ignored starts ----------------
      clear_stats();
      i_psum_valid = 1'b1;
      run_job(0, 'h3FF, 1, 'h80, 1, 'h100, 1);
      wait_idle("job3_idle", 200);
      i_psum_valid = 1'b0;
      check_val("job3_sb_empty", 32'(exp_q.size()), 32'd0);
      check_val("job3_psum_ren_count", 32'(ren_cnt), 32'd1);

      // ---------------- job 4: reset in the middle of IFM_WR ----------------
      clear_stats();
      run_job(0, 0, 1, 'h200, 3, 0, 0);
      n = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (o_wen_ifmap != '0) n++;
         if (n == 2) break;
      end
      check_val("job4_reached_ifm_wr", 32'(n), 32'd2);
      #2;
      rst_n        = 1'b0;
      i_psum_valid = 1'b1;
      #1;
      mon_en = 1'b0;
      exp_q.delete();
      check_outputs_zero("reset_async");
      repeat (2) @(negedge clk);
      check_outputs_zero("reset_hold");
      i_psum_valid = 1'b0;
      @(posedge clk); #1;
      rst_n  = 1'b1;
      mon_en = 1'b1;

      // ---------------- job 5: fresh job after reset ----------------
      clear_stats();
      run_job(0, 'h10, 3, 'h30, 1, 0, 0);
      wait_idle("job5_idle", 200);
      check_val("job5_sb_empty", 32'(exp_q.size()), 32'd0);
      check_val("job5_busy_cycles", 32'(busy_cnt), 32'd16);

      repeat (2) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
